// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard / stall / flush controller for a 5-stage core (init, load-use, branch, fetch/data-memory stalls, halt).
// Latency : all enables and flushes are combinational from the registered FSM state and current inputs (same cycle).
// Backpressure : dmem_busy freezes every pipeline register; imem_busy holds the PC and inserts an IF/ID bubble.
//
// Ports:
//   clk, rst (async, active-low)
//   ifid_rs/ifid_rt [2:0] + _vld : sources read by the instruction in IF/ID
//   idex_memread, idex_rd [2:0]  : load in ID/EX and its destination
//   branch_taken, imem_busy, dmem_busy, halt_wb
//   pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_write, halted
//   state [1:0]                  : INIT=0, RUN=1, MEM=2, HLT=3
//   stall_cnt [15:0]             : only when HAZARD_CTRL_STALL_CNT_EN is defined
//
// Build option: define HAZARD_CTRL_STALL_CNT_EN to add the saturating stall counter.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ifid_rs,
  input  logic [2:0] ifid_rt,
  input  logic       ifid_rs_vld,
  input  logic       ifid_rt_vld,
  input  logic       idex_memread,
  input  logic [2:0] idex_rd,
  input  logic       branch_taken,
  input  logic       imem_busy,
  input  logic       dmem_busy,
  input  logic       halt_wb,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_flush,
  output logic       exmem_write,
  output logic       memwb_write,
  output logic       halted,
  output logic [1:0] state
`ifdef HAZARD_CTRL_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_MEM  = 2'd2,
    ST_HLT  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] init_cnt_q;
  logic [1:0] init_cnt_d;
  logic       load_use;

  // Register 0 is compared like any other register: the core never hardwires it.
  assign load_use = idex_memread &&
                    ((ifid_rs_vld && (ifid_rs == idex_rd)) ||
                     (ifid_rt_vld && (ifid_rt == idex_rd)));

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b0;
    memwb_write = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Three cycles of bubbles after reset so every stage starts empty.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        init_cnt_d = init_cnt_q + 2'd1;
        if (init_cnt_q == 2'd2) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_MEM: begin
        // Halt is recorded even when a data access freezes this cycle.
        if (halt_wb) begin
          state_d = ST_HLT;
        end else if (dmem_busy) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_RUN;
        end

        // The cycle that leaves MEM is evaluated exactly like RUN so a
        // branch or load-use that waited behind the freeze is acted on now.
        if (dmem_busy) begin
          // Full freeze: every write enable and flush stays low.
          pc_write = 1'b0;
        end else if (branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_write  = 1'b1;
          idex_flush  = 1'b1;
          exmem_write = 1'b1;
          memwb_write = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, send a bubble into EX.
          idex_write  = 1'b1;
          idex_flush  = 1'b1;
          exmem_write = 1'b1;
          memwb_write = 1'b1;
        end else if (imem_busy) begin
          // Hold PC, IF/ID takes a bubble, older instructions keep draining.
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          memwb_write = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          memwb_write = 1'b1;
        end
      end

      ST_HLT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

`ifdef HAZARD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts cycles where the PC is held while the core is live; saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
    end else if (((state_q == ST_RUN) || (state_q == ST_MEM)) &&
                 !pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl; behavioural model checked every cycle plus literal pinned cases.
// Latency : inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure : n/a (bench drives every input directly).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] ifid_rs;
  logic [2:0] ifid_rt;
  logic       ifid_rs_vld;
  logic       ifid_rt_vld;
  logic       idex_memread;
  logic [2:0] idex_rd;
  logic       branch_taken;
  logic       imem_busy;
  logic       dmem_busy;
  logic       halt_wb;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_write;
  logic       memwb_write;
  logic       halted;
  logic [1:0] state;
`ifdef HAZARD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_rs_vld  (ifid_rs_vld),
    .ifid_rt_vld  (ifid_rt_vld),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .branch_taken (branch_taken),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .halt_wb      (halt_wb),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .halted       (halted),
    .state        (state)
`ifdef HAZARD_CTRL_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model only remembers: how many bubble cycles remain after reset,
  // whether a halt has been seen, whether the last cycle was a data-memory
  // wait, and the stall total. Outputs are derived from the priority rules.
  int          m_init_left;
  bit          m_halted;
  bit          m_mem;
  logic [15:0] m_stall;
  logic [9:0]  exp_v;
  logic [9:0]  act_v;
  logic [1:0]  es;
  bit          m_lu;

  // Packing: {state, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, halted}
  always @(negedge clk) begin
    if (!rst) begin
      m_init_left = 3;
      m_halted    = 0;
      m_mem       = 0;
      m_stall     = 16'd0;
      exp_v       = {2'd0, 8'b0010_1000};
    end else if (m_init_left > 0) begin
      exp_v = {2'd0, 8'b0010_1000};
    end else if (m_halted) begin
      exp_v = {2'd3, 8'b0000_0001};
    end else begin
      es   = m_mem ? 2'd2 : 2'd1;
      m_lu = idex_memread && ((ifid_rs_vld && ifid_rs == idex_rd) ||
                              (ifid_rt_vld && ifid_rt == idex_rd));
      if (dmem_busy)         exp_v = {es, 8'b0000_0000};
      else if (branch_taken) exp_v = {es, 8'b1111_1110};
      else if (m_lu)         exp_v = {es, 8'b0001_1110};
      else if (imem_busy)    exp_v = {es, 8'b0111_0110};
      else                   exp_v = {es, 8'b1101_0110};
    end

    act_v = {state, pc_write, ifid_write, ifid_flush, idex_write,
             idex_flush, exmem_write, memwb_write, halted};
    chk("cycle_outputs", {22'd0, act_v}, {22'd0, exp_v});
`ifdef HAZARD_CTRL_STALL_CNT_EN
    chk("cycle_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
`endif

    // Advance to what the next rising edge should produce.
    if (rst) begin
      if (m_init_left > 0) begin
        m_init_left = m_init_left - 1;
      end else if (!m_halted) begin
        if (!exp_v[7] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (halt_wb) m_halted = 1;
        else         m_mem    = dmem_busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    ifid_rs      = 3'd0;
    ifid_rt      = 3'd0;
    ifid_rs_vld  = 1'b0;
    ifid_rt_vld  = 1'b0;
    idex_memread = 1'b0;
    idex_rd      = 3'd0;
    branch_taken = 1'b0;
    imem_busy    = 1'b0;
    dmem_busy    = 1'b0;
    halt_wb      = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    quiet();

    // Reset state while rst is held low.
    sample();
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_pc_write", {31'd0, pc_write}, 32'd0);

    // Release: three INIT cycles with IF/ID flushed, then RUN.
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("init_state", {30'd0, state}, 32'd0);
      chk("init_ifid_flush", {31'd0, ifid_flush}, 32'd1);
      chk("init_pc_write", {31'd0, pc_write}, 32'd0);
    end
    sample();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_pc_write", {31'd0, pc_write}, 32'd1);

    // Load-use on rs for one cycle.
    next_cycle();
    idex_memread = 1'b1; idex_rd = 3'd3; ifid_rs = 3'd3; ifid_rs_vld = 1'b1;
    sample();
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_ifid_write", {31'd0, ifid_write}, 32'd0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("lu_exmem_write", {31'd0, exmem_write}, 32'd1);
    next_cycle();
    quiet();
    sample();
    chk("lu_gone_pc_write", {31'd0, pc_write}, 32'd1);
    chk("lu_gone_idex_flush", {31'd0, idex_flush}, 32'd0);

    // Register 0 hazard on rt, valid only through rt_vld.
    next_cycle();
    idex_memread = 1'b1; idex_rd = 3'd0; ifid_rt = 3'd0; ifid_rt_vld = 1'b1; ifid_rs = 3'd5;
    sample();
    chk("lu_r0_pc_write", {31'd0, pc_write}, 32'd0);

    // Load-use plus branch: branch wins.
    next_cycle();
    quiet();
    idex_memread = 1'b1; idex_rd = 3'd3; ifid_rs = 3'd3; ifid_rs_vld = 1'b1; branch_taken = 1'b1;
    sample();
    chk("br_pc_write", {31'd0, pc_write}, 32'd1);
    chk("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_idex_flush", {31'd0, idex_flush}, 32'd1);

    // Fetch stall with load-use: load-use response.
    next_cycle();
    branch_taken = 1'b0; imem_busy = 1'b1;
    sample();
    chk("imem_lu_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    chk("imem_lu_ifid_write", {31'd0, ifid_write}, 32'd0);

    // dmem_busy for 4 cycles with branch held.
    next_cycle();
    quiet();
    dmem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("freeze_pc_write", {31'd0, pc_write}, 32'd0);
      chk("freeze_flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
      chk("freeze_state", {30'd0, state}, (i == 0) ? 32'd1 : 32'd2);
      if (i < 3) next_cycle();
    end
    next_cycle();
    dmem_busy = 1'b0;
    sample();
    chk("mem_exit_pc_write", {31'd0, pc_write}, 32'd1);
    chk("mem_exit_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("mem_exit_state", {30'd0, state}, 32'd2);
    next_cycle();
    branch_taken = 1'b0;
    sample();
    chk("back_to_run", {30'd0, state}, 32'd1);

`ifdef HAZARD_CTRL_STALL_CNT_EN
    // Saturation of the stall counter.
    force dut.stall_cnt_q = 16'hFFFE;
    m_stall = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    next_cycle();
    imem_busy = 1'b1;
    repeat (3) next_cycle();
    imem_busy = 1'b0;
    sample();
    chk("stall_cnt_saturate", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    // Halt in RUN, then inputs ignored until reset.
    next_cycle();
    halt_wb = 1'b1;
    sample();
    chk("halt_cycle_halted", {31'd0, halted}, 32'd0);
    next_cycle();
    halt_wb = 1'b0;
    sample();
    chk("hlt_state", {30'd0, state}, 32'd3);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      branch_taken = 1'($urandom);
      dmem_busy    = 1'($urandom);
      sample();
      chk("hlt_sticky", {22'd0, state, pc_write, ifid_write, ifid_flush, idex_write,
                         idex_flush, exmem_write, memwb_write, halted}, {22'd0, 2'd3, 8'b0000_0001});
    end
    next_cycle();
    rst = 1'b0;
    sample();
    chk("hlt_reset_state", {30'd0, state}, 32'd0);
    chk("hlt_reset_halted", {31'd0, halted}, 32'd0);
    next_cycle();
    rst = 1'b1;
    quiet();

    // Randomized traffic checked by the model.
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0 || (m_halted && $urandom_range(0, 19) == 0)) rst = 1'b0;
      ifid_rs      = 3'($urandom_range(0, 3));
      ifid_rt      = 3'($urandom_range(0, 3));
      ifid_rs_vld  = 1'($urandom);
      ifid_rt_vld  = 1'($urandom);
      idex_rd      = 3'($urandom_range(0, 3));
      idex_memread = 1'($urandom);
      branch_taken = ($urandom_range(0, 6) == 0);
      imem_busy    = ($urandom_range(0, 3) == 0);
      if (dmem_busy) dmem_busy = ($urandom_range(0, 9) < 6);
      else           dmem_busy = ($urandom_range(0, 11) == 0);
      halt_wb      = ($urandom_range(0, 149) == 0);
    end
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
